mem_port_arbiter: RTL

Shares the processor's single-port, synchronous-read unified memory among three requesters: instruction fetch (IF), data load/store (D) and an external program loader (LD). Grants at most one access per cycle under fixed priority LD > D > IF, with an anti-starvation override for IF and a loader lock for uninterrupted program downloads. Read data returns one cycle after grant, steered to the granted requester. Sits between the core's fetch/data paths and the memory instance.

---
 rtl/mem_port_arbiter.sv | 112 +++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for fetch, data and loader requesters.
// Fixed priority LD > D > IF, with an IF starvation override and a loader bus lock.
module mem_port_arbiter #(
  parameter int unsigned ADDR_W       = 32,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              reset_n_i,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  input  logic              d_req_i,
  input  logic              d_we_i,
  input  logic [ADDR_W-1:0] d_addr_i,
  input  logic [DATA_W-1:0] d_wdata_i,
  output logic              d_gnt_o,
  output logic              d_rvalid_o,
  input  logic              ld_req_i,
  input  logic              ld_we_i,
  input  logic              ld_lock_i,
  input  logic [ADDR_W-1:0] ld_addr_i,
  input  logic [DATA_W-1:0] ld_wdata_i,
  output logic              ld_gnt_o,
  output logic              ld_rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e          state_q;
  logic [CntW-1:0] starve_q;
  logic [2:0]      tag_q;  // {ld, d, if} read in flight
  logic            starved;

  assign starved = (starve_q == CntW'(STARVE_LIMIT)) && if_req_i;

  always_comb begin
    if_gnt_o = 1'b0;
    d_gnt_o  = 1'b0;
    ld_gnt_o = 1'b0;
    if (reset_n_i) begin
      if (state_q == StLocked) begin
        ld_gnt_o = ld_req_i;
      end else if (starved) begin
        if_gnt_o = 1'b1;
      end else if (ld_req_i) begin
        ld_gnt_o = 1'b1;
      end else if (d_req_i) begin
        d_gnt_o = 1'b1;
      end else if (if_req_i) begin
        if_gnt_o = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    if (ld_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = ld_we_i;
      mem_addr_o  = ld_addr_i;
      mem_wdata_o = ld_wdata_i;
    end else if (d_gnt_o) begin
      mem_en_o    = 1'b1;
      mem_we_o    = d_we_i;
      mem_addr_o  = d_addr_i;
      mem_wdata_o = d_wdata_i;
    end else if (if_gnt_o) begin
      mem_en_o   = 1'b1;
      mem_addr_o = if_addr_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n_i) begin
      state_q  <= StIdle;
      starve_q <= '0;
      tag_q    <= '0;
    end else begin
      unique case (state_q)
        StIdle:   if (ld_gnt_o && ld_lock_i) state_q <= StLocked;
        StLocked: if (!ld_lock_i) state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
      // Counter keeps climbing while locked so IF wins the first idle cycle.
      if (if_req_i && !if_gnt_o) begin
        if (starve_q != CntW'(STARVE_LIMIT)) starve_q <= starve_q + 1'b1;
      end else begin
        starve_q <= '0;
      end
      tag_q <= {ld_gnt_o && !ld_we_i, d_gnt_o && !d_we_i, if_gnt_o};
    end
  end

  assign if_rvalid_o = tag_q[0];
  assign d_rvalid_o  = tag_q[1];
  assign ld_rvalid_o = tag_q[2];
  assign rdata_o     = mem_rdata_i;

endmodule
